// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall-code constants, controller state and bubble-count lookup
package pipe_ctrl_pkg;
  localparam logic [1:0] STALL_NONE = 2'd0;
  localparam logic [1:0] STALL_P2   = 2'd1;
  localparam logic [1:0] STALL_P3   = 2'd2;
  localparam logic [1:0] STALL_RSV  = 2'd3;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  // The reserved code is treated as the worst-case hazard
  function automatic int req_count(input logic [1:0] code, input int p2, input int p3);
    return code == STALL_P2 ? p2 :
           code == STALL_P3 ? p3 :
           code == STALL_RSV ? (p2 > p3 ? p2 : p3) : 0;
  endfunction
endpackage

// File: rtl/stall_controller_bubble_counter.sv
// bubble_counter: loadable down-counter with freeze input and done flag (count==1)
module bubble_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_freeze,
  input  logic         i_dec,
  input  logic [W-1:0] i_val,
  output logic         o_done
);
  logic [W-1:0] r_cnt;

  // Load wins over decrement; freeze holds the count; never wraps below zero
  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else if (!i_freeze) r_cnt <= i_load ? i_val : (i_dec && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
  end

  assign o_done = r_cnt == W'(1);
endmodule

// File: rtl/stall_controller.sv
// stall_controller: turns hazard codes and branch resolution into pipeline holds, bubbles and flushes (STALL_STATS_EN adds a stall-cycle counter)
module stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int BUBBLES_P2   = 2,
  parameter int BUBBLES_P3   = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  i_stall_code,
  input  logic        i_p1_valid,
  input  logic        i_branch_taken,
  input  logic        i_ext_hold,
  output logic        o_pc_en,
  output logic        o_ifid_en,
  output logic        o_ifid_flush,
  output logic        o_idex_bubble,
  output logic        o_busy,
  output logic [31:0] o_stall_cycles
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] w_n, w_load_val;
  logic             w_hazard, w_load, w_done, w_flush, w_stall;

  assign w_n      = CNT_W'(req_count(i_stall_code, BUBBLES_P2, BUBBLES_P3));
  assign w_hazard = i_p1_valid && i_stall_code != STALL_NONE;

  bubble_counter #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_freeze(i_ext_hold),
    .i_dec   (r_state != RUN),
    .i_val   (w_load_val),
    .o_done  (w_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RUN;
    else r_state <= w_next;
  end

  // Next state and counter load; a taken branch pre-empts any stall
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = w_n - ONE;
    if (!i_ext_hold) begin
      if (i_branch_taken) begin
        w_next     = FLUSH_CYCLES > 1 ? FLUSH : RUN;
        w_load     = FLUSH_CYCLES > 1;
        w_load_val = CNT_W'(FLUSH_CYCLES - 1);
      end else if (r_state == RUN && w_hazard) begin
        w_next = w_n > ONE ? STALL : RUN;
        w_load = w_n > ONE;
      end else if (r_state != RUN && w_done) begin
        w_next = RUN;
      end
    end
  end

  // Pipeline controls; memory wait freezes everything
  always_comb begin
    w_flush       = !i_ext_hold && (i_branch_taken || r_state == FLUSH);
    w_stall       = !i_ext_hold && !w_flush && (r_state == STALL || (r_state == RUN && w_hazard));
    o_pc_en       = !i_ext_hold && !w_stall;
    o_ifid_en     = !i_ext_hold && !w_stall;
    o_ifid_flush  = w_flush;
    o_idex_bubble = w_flush || w_stall;
    o_busy        = r_state != RUN;
  end

`ifdef STALL_STATS_EN
  logic [31:0] r_stall_cycles;

  // Count hazard bubbles only, not branch flush bubbles
  always_ff @(posedge clk) begin
    if (!rst_n) r_stall_cycles <= '0;
    else if (w_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign o_stall_cycles = r_stall_cycles;
`else
  assign o_stall_cycles = 32'd0;
`endif
endmodule
